// File: rtl/hsv_core_trap_seq.sv
// Trap/flush sequencer: turns commit-stage flush, trap, mret and wfi events plus
// interrupts into CSR update pulses and a held pipeline-flush handshake.
package hsv_core_trap_seq_pkg;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  exception_t;

    localparam exception_t EXC_INSN_MISALIGNED  = 4'd0;
    localparam exception_t EXC_INSN_FAULT       = 4'd1;
    localparam exception_t EXC_ILLEGAL_INSN     = 4'd2;
    localparam exception_t EXC_BREAKPOINT       = 4'd3;
    localparam exception_t EXC_LOAD_MISALIGNED  = 4'd4;
    localparam exception_t EXC_LOAD_FAULT       = 4'd5;
    localparam exception_t EXC_STORE_MISALIGNED = 4'd6;
    localparam exception_t EXC_STORE_FAULT      = 4'd7;
    localparam exception_t EXC_ECALL_U          = 4'd8;
    localparam exception_t EXC_ECALL_S          = 4'd9;
    localparam exception_t EXC_ECALL_M          = 4'd11;

    typedef struct packed {
        word_t      epc;
        word_t      value;
        exception_t cause;
        logic       irq;
        logic [3:0] irq_code;
    } trap_info_t;
endpackage

module hsv_core_trap_seq
    import hsv_core_trap_seq_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic       clk_core,
    input  logic       rst_core_n,

    input  logic       ctrl_flush_begin,
    input  logic       ctrl_commit,
    input  logic       ctrl_trap,
    input  logic       ctrl_mode_return,
    input  logic       ctrl_wait_irq,
    input  exception_t ctrl_trap_cause,
    input  word_t      ctrl_trap_value,
    input  word_t      ctrl_next_pc,
    output logic       ctrl_begin_irq,

    output logic       flush_req,
    output word_t      flush_target,
    input  logic       flush_ack,

    input  logic       irq_pending,
    input  logic [3:0] irq_code,

    input  word_t      mtvec_base,
    input  logic       mtvec_vectored,
    input  word_t      mepc,

    output logic       trap_we,
    output word_t      trap_epc,
    output word_t      trap_value,
    output exception_t trap_cause,
    output logic       trap_irq,
    output logic [3:0] trap_irq_code,

    output logic       mret_we
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESOLVE,
        ST_REQ,
        ST_RELEASE,
        ST_WFI
    } state_t;

    state_t     r_state;
    logic       r_irq_flag;
    logic       r_flush_req;
    word_t      r_flush_target;
    logic       r_trap_we;
    logic       r_mret_we;
    trap_info_t r_trap;

    word_t      w_base;
    word_t      w_irq_vec;
    logic       w_begin_irq;
    logic       w_unused;

    // mtvec mode bits live in [1:0]; the caller already split them out
    assign w_unused    = &{1'b0, mtvec_base[1:0]};
    assign w_base      = {mtvec_base[31:2], 2'b00};
    assign w_irq_vec   = w_base + (mtvec_vectored ? {26'd0, irq_code, 2'b00} : 32'd0);

    // An interrupt only steals a committing instruction that is not itself flushing
    assign w_begin_irq = rst_core_n && (r_state == ST_IDLE) && irq_pending
                         && ctrl_commit && !ctrl_flush_begin;

    always_ff @(posedge clk_core) begin
        if (!rst_core_n) begin
            r_state        <= ST_IDLE;
            r_irq_flag     <= 1'b0;
            r_flush_req    <= 1'b0;
            r_flush_target <= RESET_PC;
            r_trap_we      <= 1'b0;
            r_mret_we      <= 1'b0;
            r_trap         <= '0;
        end else begin
            r_trap_we <= 1'b0;
            r_mret_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_flush_begin) begin
                        r_state    <= ST_RESOLVE;
                        r_irq_flag <= 1'b0;
                    end else if (w_begin_irq) begin
                        r_state    <= ST_RESOLVE;
                        r_irq_flag <= 1'b1;
                    end
                end

                ST_RESOLVE: begin
                    r_irq_flag  <= 1'b0;
                    r_flush_req <= 1'b1;
                    r_state     <= ST_REQ;
                    if (r_irq_flag) begin
                        r_trap_we       <= 1'b1;
                        r_trap.epc      <= ctrl_next_pc;
                        r_trap.value    <= '0;
                        r_trap.cause    <= exception_t'(irq_code);
                        r_trap.irq      <= 1'b1;
                        r_trap.irq_code <= irq_code;
                        r_flush_target  <= w_irq_vec;
                    end else if (ctrl_trap) begin
                        r_trap_we       <= 1'b1;
                        r_trap.epc      <= ctrl_next_pc;
                        r_trap.value    <= ctrl_trap_value;
                        r_trap.cause    <= ctrl_trap_cause;
                        r_trap.irq      <= 1'b0;
                        r_trap.irq_code <= '0;
                        r_flush_target  <= w_base;
                    end else if (ctrl_mode_return) begin
                        r_mret_we      <= 1'b1;
                        r_flush_target <= mepc;
                    end else if (ctrl_wait_irq) begin
                        r_flush_target <= ctrl_next_pc;
                        r_state        <= ST_WFI;
                    end else begin
                        r_flush_target <= ctrl_next_pc;
                    end
                end

                ST_REQ: begin
                    if (flush_ack) begin
                        r_flush_req <= 1'b0;
                        r_state     <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!flush_ack) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_WFI: begin
                    // The held flush target is the resume pc that mepc must see
                    if (irq_pending && flush_ack) begin
                        r_trap_we       <= 1'b1;
                        r_trap.epc      <= r_flush_target;
                        r_trap.value    <= '0;
                        r_trap.cause    <= exception_t'(irq_code);
                        r_trap.irq      <= 1'b1;
                        r_trap.irq_code <= irq_code;
                        r_flush_target  <= w_irq_vec;
                        r_state         <= ST_REQ;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_flush_req <= 1'b0;
                    r_irq_flag  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_begin_irq = w_begin_irq;
    assign flush_req      = r_flush_req;
    assign flush_target   = r_flush_target;
    assign trap_we        = r_trap_we;
    assign trap_epc       = r_trap.epc;
    assign trap_value     = r_trap.value;
    assign trap_cause     = r_trap.cause;
    assign trap_irq       = r_trap.irq;
    assign trap_irq_code  = r_trap.irq_code;
    assign mret_we        = r_mret_we;

endmodule

// File: tb/tb_hsv_core_trap_seq.sv
// Directed bench for hsv_core_trap_seq: trap, irq, flush/irq race, wfi, mret, reset.
module tb_hsv_core_trap_seq;
    import hsv_core_trap_seq_pkg::*;

    localparam word_t RST_PC = 32'h0000_1000;

    logic       clk_core = 1'b0;
    logic       rst_core_n = 1'b0;
    logic       ctrl_flush_begin, ctrl_commit, ctrl_trap, ctrl_mode_return, ctrl_wait_irq;
    exception_t ctrl_trap_cause;
    word_t      ctrl_trap_value, ctrl_next_pc;
    logic       ctrl_begin_irq;
    logic       flush_req;
    word_t      flush_target;
    logic       flush_ack;
    logic       irq_pending;
    logic [3:0] irq_code;
    word_t      mtvec_base;
    logic       mtvec_vectored;
    word_t      mepc;
    logic       trap_we;
    word_t      trap_epc, trap_value;
    exception_t trap_cause;
    logic       trap_irq;
    logic [3:0] trap_irq_code;
    logic       mret_we;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_core = ~clk_core;

    hsv_core_trap_seq #(.RESET_PC(RST_PC)) dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n),
        .ctrl_flush_begin(ctrl_flush_begin), .ctrl_commit(ctrl_commit),
        .ctrl_trap(ctrl_trap), .ctrl_mode_return(ctrl_mode_return), .ctrl_wait_irq(ctrl_wait_irq),
        .ctrl_trap_cause(ctrl_trap_cause), .ctrl_trap_value(ctrl_trap_value),
        .ctrl_next_pc(ctrl_next_pc), .ctrl_begin_irq(ctrl_begin_irq),
        .flush_req(flush_req), .flush_target(flush_target), .flush_ack(flush_ack),
        .irq_pending(irq_pending), .irq_code(irq_code),
        .mtvec_base(mtvec_base), .mtvec_vectored(mtvec_vectored), .mepc(mepc),
        .trap_we(trap_we), .trap_epc(trap_epc), .trap_value(trap_value),
        .trap_cause(trap_cause), .trap_irq(trap_irq), .trap_irq_code(trap_irq_code),
        .mret_we(mret_we)
    );

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic test_reset();
        ctrl_flush_begin = 0; ctrl_commit = 1; ctrl_trap = 0; ctrl_mode_return = 0;
        ctrl_wait_irq = 0; ctrl_trap_cause = '0; ctrl_trap_value = '0; ctrl_next_pc = '0;
        flush_ack = 0; irq_pending = 1; irq_code = 0; mtvec_base = 32'h800;
        mtvec_vectored = 0; mepc = '0; rst_core_n = 0;
        tick(); tick();
        vectors++; if (flush_req !== 1'b0) begin miscompares++; $display("FAIL rst_freq: got %0b want 0", flush_req); end
        vectors++; if (flush_target !== RST_PC) begin miscompares++; $display("FAIL rst_target: got %h want %h", flush_target, RST_PC); end
        vectors++; if (trap_we !== 1'b0) begin miscompares++; $display("FAIL rst_trap_we: got %0b want 0", trap_we); end
        vectors++; if (mret_we !== 1'b0) begin miscompares++; $display("FAIL rst_mret_we: got %0b want 0", mret_we); end
        vectors++; if (ctrl_begin_irq !== 1'b0) begin miscompares++; $display("FAIL rst_begin_irq: got %0b want 0", ctrl_begin_irq); end
        irq_pending = 0; ctrl_commit = 0; rst_core_n = 1;
        tick();
    endtask

    task automatic test_trap();
        mtvec_base = 32'h800; mtvec_vectored = 0;
        ctrl_flush_begin = 1; tick();
        ctrl_flush_begin = 0; ctrl_trap = 1; ctrl_trap_cause = EXC_ILLEGAL_INSN;
        ctrl_trap_value = 32'hDEAD; ctrl_next_pc = 32'h100;
        vectors++; if (flush_req !== 1'b0) begin miscompares++; $display("FAIL trap_resolve_freq: got %0b want 0", flush_req); end
        tick();
        vectors++; if (trap_we !== 1'b1) begin miscompares++; $display("FAIL trap_we: got %0b want 1", trap_we); end
        vectors++; if (trap_irq !== 1'b0) begin miscompares++; $display("FAIL trap_irq: got %0b want 0", trap_irq); end
        vectors++; if (trap_epc !== 32'h100) begin miscompares++; $display("FAIL trap_epc: got %h want 00000100", trap_epc); end
        vectors++; if (trap_value !== 32'hDEAD) begin miscompares++; $display("FAIL trap_value: got %h want 0000dead", trap_value); end
        vectors++; if (trap_cause !== EXC_ILLEGAL_INSN) begin miscompares++; $display("FAIL trap_cause: got %0d want 2", trap_cause); end
        vectors++; if (flush_req !== 1'b1) begin miscompares++; $display("FAIL trap_freq: got %0b want 1", flush_req); end
        vectors++; if (flush_target !== 32'h800) begin miscompares++; $display("FAIL trap_target: got %h want 00000800", flush_target); end
        vectors++; if (mret_we !== 1'b0) begin miscompares++; $display("FAIL trap_mret_we: got %0b want 0", mret_we); end
        ctrl_trap = 0; tick();
        vectors++; if ({trap_we, flush_req, flush_target} !== {1'b0, 1'b1, 32'h800}) begin miscompares++;
            $display("FAIL trap_hold: got we=%0b req=%0b tgt=%h want we=0 req=1 tgt=00000800", trap_we, flush_req, flush_target); end
        flush_ack = 1; tick();
        vectors++; if (flush_req !== 1'b0) begin miscompares++; $display("FAIL trap_release_freq: got %0b want 0", flush_req); end
        flush_ack = 0; tick();
    endtask

    task automatic test_priority();
        // trap beats mret and wfi; sync trap ignores vectoring and mtvec[1:0]
        mtvec_base = 32'h807; mtvec_vectored = 1; irq_code = 4'd9;
        ctrl_flush_begin = 1; tick();
        ctrl_flush_begin = 0; ctrl_trap = 1; ctrl_mode_return = 1; ctrl_wait_irq = 1;
        ctrl_trap_cause = EXC_ECALL_M; ctrl_trap_value = 32'h5; ctrl_next_pc = 32'h80; mepc = 32'h3000;
        tick();
        vectors++; if ({trap_we, mret_we} !== 2'b10) begin miscompares++; $display("FAIL prio_trap_pulses: got %b want 10", {trap_we, mret_we}); end
        vectors++; if (flush_target !== 32'h804) begin miscompares++; $display("FAIL prio_trap_target: got %h want 00000804", flush_target); end
        vectors++; if (trap_cause !== EXC_ECALL_M) begin miscompares++; $display("FAIL prio_trap_cause: got %0d want 11", trap_cause); end
        ctrl_trap = 0; ctrl_mode_return = 0; ctrl_wait_irq = 0; flush_ack = 1; tick();
        vectors++; if (flush_req !== 1'b0) begin miscompares++; $display("FAIL prio_trap_not_wfi: got %0b want 0", flush_req); end
        flush_ack = 0; tick();
        ctrl_flush_begin = 1; tick();
        ctrl_flush_begin = 0; ctrl_mode_return = 1; ctrl_wait_irq = 1; tick();
        vectors++; if ({trap_we, mret_we} !== 2'b01) begin miscompares++; $display("FAIL prio_mret_pulses: got %b want 01", {trap_we, mret_we}); end
        vectors++; if (flush_target !== 32'h3000) begin miscompares++; $display("FAIL prio_mret_target: got %h want 00003000", flush_target); end
        ctrl_mode_return = 0; ctrl_wait_irq = 0; flush_ack = 1; tick();
        vectors++; if (flush_req !== 1'b0) begin miscompares++; $display("FAIL prio_mret_not_wfi: got %0b want 0", flush_req); end
        flush_ack = 0; tick();
    endtask

    task automatic test_irq();
        mtvec_base = 32'h800; mtvec_vectored = 1; irq_code = 4'd7; ctrl_next_pc = 32'h204;
        irq_pending = 1; ctrl_commit = 1; #1;
        vectors++; if (ctrl_begin_irq !== 1'b1) begin miscompares++; $display("FAIL irq_begin: got %0b want 1", ctrl_begin_irq); end
        tick();
        vectors++; if (ctrl_begin_irq !== 1'b0) begin miscompares++; $display("FAIL irq_begin_resolve: got %0b want 0", ctrl_begin_irq); end
        tick();
        vectors++; if ({trap_we, trap_irq} !== 2'b11) begin miscompares++; $display("FAIL irq_we_irq: got %b want 11", {trap_we, trap_irq}); end
        vectors++; if (trap_irq_code !== 4'd7) begin miscompares++; $display("FAIL irq_code: got %0d want 7", trap_irq_code); end
        vectors++; if (trap_epc !== 32'h204) begin miscompares++; $display("FAIL irq_epc: got %h want 00000204", trap_epc); end
        vectors++; if (trap_value !== 32'h0) begin miscompares++; $display("FAIL irq_value: got %h want 00000000", trap_value); end
        vectors++; if (flush_target !== 32'h81C) begin miscompares++; $display("FAIL irq_target: got %h want 0000081c", flush_target); end
        vectors++; if (flush_req !== 1'b1) begin miscompares++; $display("FAIL irq_freq: got %0b want 1", flush_req); end
        irq_pending = 0; ctrl_commit = 0; flush_ack = 1; tick();
        vectors++; if ({flush_req, trap_we} !== 2'b00) begin miscompares++; $display("FAIL irq_release: got %b want 00", {flush_req, trap_we}); end
        flush_ack = 0; tick();
    endtask

    task automatic test_flush_vs_irq();
        mtvec_base = 32'h800; mtvec_vectored = 1; irq_code = 4'd3; ctrl_next_pc = 32'h300;
        ctrl_flush_begin = 1; irq_pending = 1; ctrl_commit = 1; #1;
        vectors++; if (ctrl_begin_irq !== 1'b0) begin miscompares++; $display("FAIL race_begin: got %0b want 0", ctrl_begin_irq); end
        tick();
        ctrl_flush_begin = 0; ctrl_commit = 0; tick();
        vectors++; if (trap_we !== 1'b0) begin miscompares++; $display("FAIL race_no_trap: got %0b want 0", trap_we); end
        vectors++; if ({flush_req, flush_target} !== {1'b1, 32'h300}) begin miscompares++;
            $display("FAIL race_flush: got req=%0b tgt=%h want req=1 tgt=00000300", flush_req, flush_target); end
        flush_ack = 1; tick();
        ctrl_commit = 1; #1;
        vectors++; if (ctrl_begin_irq !== 1'b0) begin miscompares++; $display("FAIL race_begin_release: got %0b want 0", ctrl_begin_irq); end
        flush_ack = 0; ctrl_next_pc = 32'h304; tick();
        vectors++; if (ctrl_begin_irq !== 1'b1) begin miscompares++; $display("FAIL race_begin_idle: got %0b want 1", ctrl_begin_irq); end
        tick();
        irq_pending = 0; ctrl_commit = 0; tick();
        vectors++; if ({trap_we, trap_irq, trap_irq_code} !== {2'b11, 4'd3}) begin miscompares++;
            $display("FAIL race_irq: got we=%0b irq=%0b code=%0d want we=1 irq=1 code=3", trap_we, trap_irq, trap_irq_code); end
        vectors++; if ({trap_epc, flush_target} !== {32'h304, 32'h80C}) begin miscompares++;
            $display("FAIL race_irq_pc: got epc=%h tgt=%h want epc=00000304 tgt=0000080c", trap_epc, flush_target); end
        flush_ack = 1; tick(); flush_ack = 0; tick();
    endtask

    task automatic test_wfi();
        mtvec_base = 32'h800; mtvec_vectored = 1; irq_code = 4'd5;
        ctrl_flush_begin = 1; tick();
        ctrl_flush_begin = 0; ctrl_wait_irq = 1; ctrl_next_pc = 32'h40; tick();
        vectors++; if ({flush_req, trap_we, flush_target} !== {2'b10, 32'h40}) begin miscompares++;
            $display("FAIL wfi_enter: got req=%0b we=%0b tgt=%h want req=1 we=0 tgt=00000040", flush_req, trap_we, flush_target); end
        // irq without ack must not wake
        ctrl_wait_irq = 0; ctrl_next_pc = 32'h999; irq_pending = 1; tick();
        vectors++; if ({flush_req, trap_we, flush_target} !== {2'b10, 32'h40}) begin miscompares++;
            $display("FAIL wfi_noack: got req=%0b we=%0b tgt=%h want req=1 we=0 tgt=00000040", flush_req, trap_we, flush_target); end
        irq_pending = 0; flush_ack = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++; if ({flush_req, trap_we, flush_target} !== {2'b10, 32'h40}) begin miscompares++;
                $display("FAIL wfi_hold%0d: got req=%0b we=%0b tgt=%h want req=1 we=0 tgt=00000040", i, flush_req, trap_we, flush_target); end
        end
        irq_pending = 1; tick();
        vectors++; if ({trap_we, trap_irq, trap_irq_code} !== {2'b11, 4'd5}) begin miscompares++;
            $display("FAIL wfi_wake: got we=%0b irq=%0b code=%0d want we=1 irq=1 code=5", trap_we, trap_irq, trap_irq_code); end
        vectors++; if (trap_epc !== 32'h40) begin miscompares++; $display("FAIL wfi_epc: got %h want 00000040", trap_epc); end
        vectors++; if ({flush_req, flush_target} !== {1'b1, 32'h814}) begin miscompares++;
            $display("FAIL wfi_vec: got req=%0b tgt=%h want req=1 tgt=00000814", flush_req, flush_target); end
        irq_pending = 0; tick();
        vectors++; if ({flush_req, trap_we} !== 2'b00) begin miscompares++; $display("FAIL wfi_release: got %b want 00", {flush_req, trap_we}); end
        flush_ack = 0; tick();
    endtask

    task automatic test_mret();
        mtvec_vectored = 0;
        ctrl_flush_begin = 1; tick();
        ctrl_flush_begin = 0; ctrl_mode_return = 1; mepc = 32'h3000; ctrl_next_pc = 32'h60; tick();
        vectors++; if ({mret_we, trap_we} !== 2'b10) begin miscompares++; $display("FAIL mret_pulse: got %b want 10", {mret_we, trap_we}); end
        vectors++; if ({flush_req, flush_target} !== {1'b1, 32'h3000}) begin miscompares++;
            $display("FAIL mret_target: got req=%0b tgt=%h want req=1 tgt=00003000", flush_req, flush_target); end
        ctrl_mode_return = 0; mepc = 32'h4000;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if ({flush_req, mret_we, flush_target} !== {2'b10, 32'h3000}) begin miscompares++;
                $display("FAIL mret_hold%0d: got req=%0b we=%0b tgt=%h want req=1 we=0 tgt=00003000", i, flush_req, mret_we, flush_target); end
        end
        flush_ack = 1; tick();
        vectors++; if (flush_req !== 1'b0) begin miscompares++; $display("FAIL mret_release: got %0b want 0", flush_req); end
        flush_ack = 0; tick();
    endtask

    task automatic test_irq_wrap();
        mtvec_base = 32'hFFFF_FFF3; mtvec_vectored = 1; irq_code = 4'hF; ctrl_next_pc = 32'h10;
        irq_pending = 1; ctrl_commit = 1; #1;
        vectors++; if (ctrl_begin_irq !== 1'b1) begin miscompares++; $display("FAIL wrap_begin: got %0b want 1", ctrl_begin_irq); end
        tick();
        irq_pending = 0; ctrl_commit = 0; tick();
        vectors++; if ({trap_we, trap_epc, flush_target} !== {1'b1, 32'h10, 32'h2C}) begin miscompares++;
            $display("FAIL wrap_target: got we=%0b epc=%h tgt=%h want we=1 epc=00000010 tgt=0000002c", trap_we, trap_epc, flush_target); end
        flush_ack = 1; tick(); flush_ack = 0; tick();
    endtask

    task automatic test_reset_mid_flush();
        ctrl_flush_begin = 1; tick();
        ctrl_flush_begin = 0; ctrl_next_pc = 32'h700; tick();
        vectors++; if ({flush_req, flush_target} !== {1'b1, 32'h700}) begin miscompares++;
            $display("FAIL rstm_req: got req=%0b tgt=%h want req=1 tgt=00000700", flush_req, flush_target); end
        rst_core_n = 0; irq_pending = 1; ctrl_commit = 1; tick();
        vectors++; if ({flush_req, trap_we, flush_target} !== {2'b00, RST_PC}) begin miscompares++;
            $display("FAIL rstm_clear: got req=%0b we=%0b tgt=%h want req=0 we=0 tgt=%h", flush_req, trap_we, flush_target, RST_PC); end
        vectors++; if (ctrl_begin_irq !== 1'b0) begin miscompares++; $display("FAIL rstm_begin_in_rst: got %0b want 0", ctrl_begin_irq); end
        rst_core_n = 1; #1;
        vectors++; if (ctrl_begin_irq !== 1'b1) begin miscompares++; $display("FAIL rstm_begin_after: got %0b want 1", ctrl_begin_irq); end
        tick();
        irq_pending = 0; ctrl_commit = 0; mtvec_base = 32'h800; mtvec_vectored = 0; ctrl_next_pc = 32'h720; tick();
        vectors++; if ({trap_we, trap_irq, flush_target} !== {2'b11, 32'h800}) begin miscompares++;
            $display("FAIL rstm_irq: got we=%0b irq=%0b tgt=%h want we=1 irq=1 tgt=00000800", trap_we, trap_irq, flush_target); end
        flush_ack = 1; tick(); flush_ack = 0; tick();
        // reset while waiting for an interrupt, then reset over a resolving trap
        ctrl_flush_begin = 1; tick();
        ctrl_flush_begin = 0; ctrl_wait_irq = 1; ctrl_next_pc = 32'h900; tick();
        vectors++; if (flush_req !== 1'b1) begin miscompares++; $display("FAIL rstw_wfi: got %0b want 1", flush_req); end
        ctrl_wait_irq = 0; rst_core_n = 0; tick();
        vectors++; if ({flush_req, flush_target} !== {1'b0, RST_PC}) begin miscompares++;
            $display("FAIL rstw_clear: got req=%0b tgt=%h want req=0 tgt=%h", flush_req, flush_target, RST_PC); end
        rst_core_n = 1; ctrl_flush_begin = 1; tick();
        ctrl_flush_begin = 0; ctrl_trap = 1; rst_core_n = 0; tick();
        vectors++; if ({trap_we, flush_req} !== 2'b00) begin miscompares++; $display("FAIL rstt_clear: got %b want 00", {trap_we, flush_req}); end
        ctrl_trap = 0; rst_core_n = 1; tick();
        vectors++; if ({trap_we, flush_req} !== 2'b00) begin miscompares++; $display("FAIL rstt_idle: got %b want 00", {trap_we, flush_req}); end
    endtask

    initial begin
        test_reset();
        test_trap();
        test_priority();
        test_irq();
        test_flush_vs_irq();
        test_wfi();
        test_mret();
        test_irq_wrap();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
